// File: rtl/ili9341_par8_lcd_ctrl.sv
// ili9341_par8_lcd_ctrl
//   Drives an ILI9341 TFT over its 8080-style 8-bit parallel write bus.
//   After reset: pulse the panel reset, wait, send an 18-byte power-up and
//   configuration sequence, then stream RGB565 pixels (one pixel per 4-clock
//   slot, two bytes per pixel) in landscape raster order.
//
// Ports
//   clk, rst_n                : bus clock, asynchronous active-low reset
//   vblank                    : frame resync request, sampled at slot start
//   write, col_r/col_g/col_b  : pixel valid + 8-bit RGB, sampled at slot start
//   lcd_rst/cs/rs/wr/rd/data  : panel pins (lcd_rd held high)
//   initialized               : high once the configuration sequence is sent
//   hsync / vsync             : high for the whole slot carrying the last pixel
//                               of a row / of a frame
//
// H_PIXELS / V_PIXELS set the raster size used by the pixel counters; they
// default to the panel's 320x240 landscape geometry.
`timescale 1ns/1ps
module ili9341_par8_lcd_ctrl #(
    parameter int unsigned RST_LOW_CYCLES    = 100000,
    parameter int unsigned RST_WAIT_CYCLES   = 1200000,
    parameter int unsigned SWRST_WAIT_CYCLES = 50000,
    parameter int unsigned SLEEP_WAIT_CYCLES = 1200000,
    parameter int unsigned H_PIXELS          = 320,
    parameter int unsigned V_PIXELS          = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblank,
    input  logic       write,
    input  logic [7:0] col_r,
    input  logic [7:0] col_g,
    input  logic [7:0] col_b,
    output logic       lcd_rst,
    output logic       lcd_cs,
    output logic       lcd_rs,
    output logic       lcd_wr,
    output logic       lcd_rd,
    output logic [7:0] lcd_data,
    output logic       initialized,
    output logic       hsync,
    output logic       vsync
);

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_CMD,
        ST_DELAY,
        ST_ACTIVE,
        ST_RESYNC
    } state_e;

    localparam logic [4:0] ROM_LAST = 5'd17;

    // Configuration sequence, {rs, byte}. rs=0 marks a command byte.
    function automatic logic [8:0] rom(input logic [4:0] idx);
        case (idx)
            5'd0:    rom = {1'b0, 8'h01};  // software reset
            5'd1:    rom = {1'b0, 8'h11};  // sleep out
            5'd2:    rom = {1'b0, 8'h3A};  // pixel format
            5'd3:    rom = {1'b1, 8'h55};  //   16 bpp
            5'd4:    rom = {1'b0, 8'h36};  // memory access control
            5'd5:    rom = {1'b1, 8'h28};  //   landscape
            5'd6:    rom = {1'b0, 8'h2A};  // column range 0..319
            5'd7:    rom = {1'b1, 8'h00};
            5'd8:    rom = {1'b1, 8'h00};
            5'd9:    rom = {1'b1, 8'h01};
            5'd10:   rom = {1'b1, 8'h3F};
            5'd11:   rom = {1'b0, 8'h2B};  // page range 0..239
            5'd12:   rom = {1'b1, 8'h00};
            5'd13:   rom = {1'b1, 8'h00};
            5'd14:   rom = {1'b1, 8'h00};
            5'd15:   rom = {1'b1, 8'hEF};
            5'd16:   rom = {1'b0, 8'h29};  // display on
            5'd17:   rom = {1'b0, 8'h2C};  // memory write
            default: rom = {1'b0, 8'h00};
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] delay_lim;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [7:0]  lo_q, lo_d;
    logic        pix_q, pix_d;
    logic        rst_q, rst_d, cs_q, cs_d, rs_q, rs_d, wr_q, wr_d;
    logic [7:0]  data_q, data_d;
    logic        init_q, init_d, hs_q, hs_d, vs_q, vs_d;
    logic        launch_byte, slot_start, slot_sample;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        x_d         = x_q;
        y_d         = y_q;
        lo_d        = lo_q;
        pix_d       = pix_q;
        rst_d       = rst_q;
        cs_d        = cs_q;
        rs_d        = rs_q;
        wr_d        = wr_q;
        data_d      = data_q;
        init_d      = init_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        delay_lim   = (idx_q == 5'd0) ? SWRST_WAIT_CYCLES : SLEEP_WAIT_CYCLES;
        launch_byte = 1'b0;
        slot_start  = 1'b0;
        slot_sample = 1'b0;

        case (state_q)
            ST_RST_LOW: begin
                if (cnt_q == RST_LOW_CYCLES - 1) begin
                    rst_d   = 1'b1;
                    cnt_d   = 32'd0;
                    state_d = ST_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == RST_WAIT_CYCLES - 1) begin
                    cs_d        = 1'b0;
                    launch_byte = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_CMD: begin
                if (phase_q == 2'd0) begin
                    wr_d    = 1'b1;
                    phase_d = 2'd1;
                end else if (idx_q <= 5'd1) begin
                    // software reset and sleep out need settle time
                    cnt_d   = 32'd0;
                    state_d = ST_DELAY;
                end else if (idx_q == ROM_LAST) begin
                    // initialized is still 0 on this edge, so this first slot
                    // ignores write and vblank
                    init_d     = 1'b1;
                    slot_start = 1'b1;
                end else begin
                    idx_d       = idx_q + 5'd1;
                    launch_byte = 1'b1;
                end
            end
            ST_DELAY: begin
                if (cnt_q == delay_lim - 1) begin
                    idx_d       = idx_q + 5'd1;
                    launch_byte = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_ACTIVE: begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: wr_d = 1'b1;
                    2'd1: begin
                        if (pix_q) begin
                            data_d = lo_q;
                            wr_d   = 1'b0;
                        end
                    end
                    2'd2: wr_d = 1'b1;
                    default: begin
                        if (pix_q) begin
                            if (x_q == 16'(H_PIXELS - 1)) begin
                                x_d = 16'd0;
                                y_d = (y_q == 16'(V_PIXELS - 1)) ? 16'd0 : y_q + 16'd1;
                            end else begin
                                x_d = x_q + 16'd1;
                            end
                        end
                        slot_start  = 1'b1;
                        slot_sample = 1'b1;
                    end
                endcase
            end
            ST_RESYNC: begin
                if (phase_q == 2'd0) begin
                    wr_d    = 1'b1;
                    phase_d = 2'd1;
                end else begin
                    slot_start  = 1'b1;
                    slot_sample = 1'b1;
                end
            end
            default: state_d = ST_RST_LOW;
        endcase

        if (launch_byte) begin
            state_d        = ST_CMD;
            phase_d        = 2'd0;
            {rs_d, data_d} = rom(idx_d);
            wr_d           = 1'b0;
        end

        // Slot start uses the already-advanced counters so hsync/vsync line
        // up with the pixel the new slot actually carries.
        if (slot_start) begin
            state_d = ST_ACTIVE;
            phase_d = 2'd0;
            rs_d    = 1'b1;
            wr_d    = 1'b1;
            pix_d   = 1'b0;
            hs_d    = 1'b0;
            vs_d    = 1'b0;
            if (slot_sample && vblank) begin
                state_d = ST_RESYNC;
                rs_d    = 1'b0;
                data_d  = 8'h2C;
                wr_d    = 1'b0;
                x_d     = 16'd0;
                y_d     = 16'd0;
            end else if (slot_sample && write) begin
                data_d = {col_r[7:3], col_g[7:5]};
                lo_d   = {col_g[4:2], col_b[7:3]};
                wr_d   = 1'b0;
                pix_d  = 1'b1;
                hs_d   = (x_d == 16'(H_PIXELS - 1));
                vs_d   = hs_d && (y_d == 16'(V_PIXELS - 1));
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST_LOW;
            cnt_q   <= 32'd0;
            idx_q   <= 5'd0;
            phase_q <= 2'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            lo_q    <= 8'h00;
            pix_q   <= 1'b0;
            rst_q   <= 1'b0;
            cs_q    <= 1'b1;
            rs_q    <= 1'b1;
            wr_q    <= 1'b1;
            data_q  <= 8'h00;
            init_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lo_q    <= lo_d;
            pix_q   <= pix_d;
            rst_q   <= rst_d;
            cs_q    <= cs_d;
            rs_q    <= rs_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            init_q  <= init_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign lcd_rst     = rst_q;
    assign lcd_cs      = cs_q;
    assign lcd_rs      = rs_q;
    assign lcd_wr      = wr_q;
    assign lcd_rd      = 1'b1;
    assign lcd_data    = data_q;
    assign initialized = init_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;

endmodule

// File: tb/tb_ili9341_par8_lcd_ctrl.sv
// tb_ili9341_par8_lcd_ctrl
//   Self-checking bench for ili9341_par8_lcd_ctrl. A slot-level reference
//   model (pixel position, RGB565 arithmetic, expected bus cycles per slot)
//   predicts every bus cycle after initialisation; the init byte stream is
//   compared against the expected command table.
`timescale 1ns/1ps
module tb_ili9341_par8_lcd_ctrl;

    localparam int H = 320;
    localparam int V = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vblank = 1'b0;
    logic       write = 1'b0;
    logic [7:0] col_r = 8'h00, col_g = 8'h00, col_b = 8'h00;
    logic       lcd_rst, lcd_cs, lcd_rs, lcd_wr, lcd_rd;
    logic [7:0] lcd_data;
    logic       initialized, hsync, vsync;

    ili9341_par8_lcd_ctrl #(
        .RST_LOW_CYCLES   (2),
        .RST_WAIT_CYCLES  (2),
        .SWRST_WAIT_CYCLES(2),
        .SLEEP_WAIT_CYCLES(2),
        .H_PIXELS         (H),
        .V_PIXELS         (V)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblank     (vblank),
        .write      (write),
        .col_r      (col_r),
        .col_g      (col_g),
        .col_b      (col_b),
        .lcd_rst    (lcd_rst),
        .lcd_cs     (lcd_cs),
        .lcd_rs     (lcd_rs),
        .lcd_wr     (lcd_wr),
        .lcd_rd     (lcd_rd),
        .lcd_data   (lcd_data),
        .initialized(initialized),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {rs, byte} in the order the panel must receive them
    localparam logic [8:0] ROM_EXP [18] = '{
        9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h128, 9'h02A, 9'h100, 9'h100,
        9'h101, 9'h13F, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h029, 9'h02C
    };

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       rs;
        logic       wr;
        logic [7:0] data;
        logic       chk;   // compare lcd_data on this cycle
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int mx = 0, my = 0;
    int exp_hs_cnt = 0, obs_hs_cnt = 0, exp_vs_cnt = 0, obs_vs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic noise();
        write  = 1'($urandom_range(0, 1));
        vblank = 1'($urandom_range(0, 1));
        col_r  = 8'($urandom);
        col_g  = 8'($urandom);
        col_b  = 8'($urandom);
    endtask

    function automatic logic [7:0] enc_hi(input int r, input int g);
        return 8'((r / 8) * 8 + g / 32);
    endfunction

    function automatic logic [7:0] enc_lo(input int g, input int b);
        return 8'(((g / 4) % 8) * 32 + b / 8);
    endfunction

    task automatic check_reset_vals(input string tag);
        check(tag, {lcd_rst, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data, initialized, hsync, vsync},
              {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    endtask

    // one comparison per bus cycle: slot outputs plus the static pins
    task automatic check_cycle(input string tag, input exp_t e);
        check(tag, {lcd_cs, lcd_rst, initialized, lcd_rd, hsync, vsync, lcd_rs, lcd_wr,
                    e.chk ? lcd_data : 8'h00},
              {4'b0111, e.hs, e.vs, e.rs, e.wr, e.chk ? e.data : 8'h00});
    endtask

    // Runs from the first cycle after reset release to the cycle where
    // initialized first reads 1 (phase 0 of the first, always idle, slot).
    task automatic run_init();
        logic [8:0] cap[$];
        logic       prev_wr0 = 1'b0;
        logic [8:0] prev_byte = 9'h000;
        int         cyc = 0;
        @(negedge clk);
        while (!initialized && cyc < 2000) begin
            if (prev_wr0)
                check("init_wr_high_hold", {lcd_wr, lcd_rs, lcd_data}, {1'b1, prev_byte});
            prev_wr0 = !lcd_wr;
            if (!lcd_wr) begin
                prev_byte = {lcd_rs, lcd_data};
                cap.push_back({lcd_rs, lcd_data});
            end
            noise();
            @(negedge clk);
            cyc++;
        end
        check("init_done", 32'(initialized), 32'd1);
        check("init_byte_count", cap.size(), 18);
        for (int i = 0; i < 18; i++)
            check($sformatf("init_byte_%0d", i), (i < cap.size()) ? cap[i] : 9'h1FF, ROM_EXP[i]);
        check("init_pins", {lcd_cs, lcd_rst, lcd_rd}, 3'b011);
        // first slot after init is idle regardless of inputs
        for (int p = 0; p < 4; p++) begin
            if (p != 0) @(negedge clk);
            check_cycle("first_slot_idle", '{hs: 1'b0, vs: 1'b0, rs: 1'b1, wr: 1'b1, data: 8'h00, chk: 1'b0});
            noise();
        end
    endtask

    // Called on the negedge just before a slot-start edge.
    task automatic do_slot(input logic vb, input logic wr, input logic [7:0] r, g, b,
                           input logic [7:0] ehi, elo, input string tag);
        exp_t recs[$];
        logic hs, vs;
        vblank = vb;
        write  = wr;
        col_r  = r;
        col_g  = g;
        col_b  = b;
        if (vb) begin
            recs.push_back('{hs: 1'b0, vs: 1'b0, rs: 1'b0, wr: 1'b0, data: 8'h2C, chk: 1'b1});
            recs.push_back('{hs: 1'b0, vs: 1'b0, rs: 1'b0, wr: 1'b1, data: 8'h2C, chk: 1'b1});
            mx = 0;
            my = 0;
        end else if (wr) begin
            hs = (mx == H - 1);
            vs = hs && (my == V - 1);
            exp_hs_cnt += int'(hs);
            exp_vs_cnt += int'(vs);
            recs.push_back('{hs: hs, vs: vs, rs: 1'b1, wr: 1'b0, data: ehi, chk: 1'b1});
            recs.push_back('{hs: hs, vs: vs, rs: 1'b1, wr: 1'b1, data: ehi, chk: 1'b1});
            recs.push_back('{hs: hs, vs: vs, rs: 1'b1, wr: 1'b0, data: elo, chk: 1'b1});
            recs.push_back('{hs: hs, vs: vs, rs: 1'b1, wr: 1'b1, data: elo, chk: 1'b1});
            mx++;
            if (mx == H) begin
                mx = 0;
                my = (my + 1) % V;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                recs.push_back('{hs: 1'b0, vs: 1'b0, rs: 1'b1, wr: 1'b1, data: 8'h00, chk: 1'b0});
        end
        for (int i = 0; i < recs.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                obs_hs_cnt += int'(hsync);
                obs_vs_cnt += int'(vsync);
            end
            check_cycle(tag, recs[i]);
            noise();
        end
    endtask

    task automatic rand_slot(input logic vb, input logic wr, input string tag);
        logic [7:0] r, g, b;
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
        do_slot(vb, wr, r, g, b, enc_hi(int'(r), int'(g)), enc_lo(int'(g), int'(b)), tag);
    endtask

    initial begin
        bit vb_done;
        int guard;

        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("reset_hold");
            noise();
        end
        rst_n = 1'b1;
        run_init();

        do_slot(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hF8, 8'h00, "pix_red");
        do_slot(1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'h07, 8'hE0, "pix_green");
        do_slot(1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h1F, "pix_blue");

        // continuous writes across a full frame and its wrap
        for (int i = 0; i < H * V + 40; i++) rand_slot(1'b0, 1'b1, "continuous");
        check("vsync_after_frame", obs_vs_cnt, exp_vs_cnt);

        // write on every other slot for two rows
        for (int i = 0; i < 4 * H; i++) rand_slot(1'b0, 1'(i % 2 == 0), "alternate");
        check("hsync_count_alt", obs_hs_cnt, exp_hs_cnt);

        // random traffic until the raster reaches (100,5), then resync there
        vb_done = 1'b0;
        guard   = 0;
        while (!vb_done && guard < 4 * H * V) begin
            if (mx == 100 && my == 5) begin
                rand_slot(1'b1, 1'b1, "vblank_resync");
                vb_done = 1'b1;
            end else begin
                rand_slot(1'b0, 1'($urandom_range(0, 3) != 0), "random");
            end
            guard++;
        end
        check("vblank_point_reached", 32'(vb_done), 32'd1);
        for (int i = 0; i < H + 10; i++) rand_slot(1'b0, 1'b1, "after_resync");
        for (int i = 0; i < 400; i++)
            rand_slot(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), "random_vb");
        check("hsync_count", obs_hs_cnt, exp_hs_cnt);
        check("vsync_count", obs_vs_cnt, exp_vs_cnt);

        // asynchronous reset in mid-frame, then full restart
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset_immediate");
        repeat (2) begin
            @(negedge clk);
            check_reset_vals("async_reset_hold");
        end
        mx = 0;
        my = 0;
        rst_n = 1'b1;
        run_init();
        do_slot(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hF8, 8'h00, "reinit_red");
        for (int i = 0; i < 20; i++) rand_slot(1'b0, 1'b1, "reinit_pix");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
